pcs_link_ctrl: RTL and testbench
================================

PCS_LINK_CTRL -- requirements
Module: pcs_link_ctrl

Interface
REQ-001 Parameter LINK_TIMER, default 16, link-timer duration in GTX_CLK cycles (legal range 2..2^20-1).
REQ-002 Parameter LOCAL_ABILITY, default 16'h0020, local advertised config word; bit 14 (ACK) SHALL be 0.
REQ-003 GTX_CLK  in  1  single clock; all state on rising edge.
REQ-004 mr_main_reset  in  1  asynchronous, active-high reset.
REQ-005 mr_an_enable  in  1  1 = run auto-negotiation; 0 = bypass to link by sync only.
REQ-006 mr_restart_an  in  1  level; forces renegotiation while high.
REQ-007 code_sync_status  in  1  receive synchronization acquired.
REQ-008 rx_cfg_valid  in  1  1-cycle strobe: one /C/ ordered set received.
REQ-009 rx_cfg_reg  in  16  config word carried by that /C/, sampled on rx_cfg_valid.
REQ-010 rx_idle_valid  in  1  1-cycle strobe: one /I/ ordered set received.
REQ-011 xmit  out  3  transmit mode to TRANSMIT/RECEIVE: 3'b001 CONFIGURATION, 3'b010 IDLE, 3'b100 DATA.
REQ-012 tx_cfg_reg  out  16  config word the transmitter sends during CONFIGURATION.
REQ-013 mr_lp_adv_ability  out  16  link partner ability latched at ability match.
REQ-014 mr_an_complete  out  1  high only in LINK_OK with mr_an_enable=1.
REQ-015 link_ok  out  1  high only in LINK_OK.

Function
REQ-016 States: AN_ENABLE, AN_RESTART, ABILITY_DETECT, ACK_DETECT, COMPLETE_ACK, IDLE_DETECT, LINK_OK; registered outputs decoded from state.
REQ-017 Outputs per state: AN_ENABLE/AN_RESTART xmit=001, tx_cfg=0; ABILITY_DETECT xmit=001, tx_cfg=LOCAL_ABILITY; ACK_DETECT/COMPLETE_ACK xmit=001, tx_cfg=LOCAL_ABILITY|16'h4000; IDLE_DETECT xmit=010; LINK_OK xmit=100; tx_cfg=0 in IDLE_DETECT/LINK_OK.
REQ-018 Link timer: 20-bit counter cleared on entry to AN_RESTART, COMPLETE_ACK, IDLE_DETECT; "done" when count = LINK_TIMER-1; saturates at done.
REQ-019 ability_match: 3 consecutive rx_cfg_valid strobes with identical rx_cfg_reg ignoring bit 14; match counter saturates at 3; any differing word reloads count to 1.
REQ-020 acknowledge_match: ability_match condition plus bit 14 = 1 on all 3 words.
REQ-021 AN_ENABLE -> AN_RESTART next cycle if mr_an_enable=1; else -> LINK_OK when code_sync_status=1.
REQ-022 AN_RESTART -> ABILITY_DETECT on timer done and mr_restart_an=0.
REQ-023 ABILITY_DETECT -> ACK_DETECT on ability_match with word[15:0]&16'hBFFF != 0; mr_lp_adv_ability loads that word same edge.
REQ-024 ACK_DETECT -> COMPLETE_ACK on acknowledge_match with word ignoring bit 14 equal to latched ability; any received word differing (ignoring bit 14) or equal to 0 -> AN_ENABLE.
REQ-025 COMPLETE_ACK -> IDLE_DETECT on timer done; received all-zero word -> AN_ENABLE.
REQ-026 IDLE_DETECT -> LINK_OK when timer done and ≥3 consecutive rx_idle_valid strobes since entry (any rx_cfg_valid clears the idle count).
REQ-027 In IDLE_DETECT or LINK_OK (AN enabled), rx_cfg_valid with nonzero word -> AN_ENABLE.
REQ-028 Global priority, highest first: reset; code_sync_status=0 -> AN_ENABLE; mr_restart_an=1 -> AN_ENABLE; per-state transitions.
REQ-029 Match and idle counters clear on every state change.

Reset
REQ-030 Asserting mr_main_reset at any time SHALL immediately force AN_ENABLE, xmit=3'b001, tx_cfg_reg=0, mr_lp_adv_ability=0, mr_an_complete=0, link_ok=0, all counters 0.
REQ-031 First transition after deassertion occurs on the second GTX_CLK rising edge.

Configuration
REQ-032 Macro PCS_LINK_DROP_CNT_EN defined: add output link_drop_cnt [7:0], increments on every exit from LINK_OK, saturates at 8'hFF, reset to 0.
REQ-033 Macro undefined: port and counter absent; all other behaviour identical.

Verification
REQ-034 Reset, sync=1, an_enable=1, partner sends 16'h0020 x3 then 16'h4020 x3, then /I/ strobes -> xmit 001 -> 010 -> 100, lp_adv=16'h0020, mr_an_complete=1.
REQ-035 AN_RESTART with LINK_TIMER=16 -> ABILITY_DETECT exactly 16 cycles after entry; tx_cfg 0 -> 16'h0020.
REQ-036 In ACK_DETECT partner sends 16'h0040 -> AN_ENABLE next edge, xmit stays 001, tx_cfg=0.
REQ-037 In LINK_OK drop code_sync_status -> next edge link_ok=0, xmit=001; with PCS_LINK_DROP_CNT_EN link_drop_cnt 0 -> 1.
REQ-038 an_enable=0, sync=1 after reset -> LINK_OK in 2 cycles, xmit=100, mr_an_complete=0.
REQ-039 Assert mr_main_reset mid-COMPLETE_ACK, asynchronous to clock -> outputs at reset values before next edge.

Source files
------------

// File: rtl/pcs_link_ctrl_if.sv
// Link-control signal bundle between the PCS receive/transmit paths and pcs_link_ctrl.
// Optional PCS_LINK_DROP_CNT_EN adds the link_drop_cnt status field.
interface pcs_link_ctrl_if;
  logic        mr_an_enable;
  logic        mr_restart_an;
  logic        code_sync_status;
  logic        rx_cfg_valid;
  logic [15:0] rx_cfg_reg;
  logic        rx_idle_valid;
  logic [2:0]  xmit;
  logic [15:0] tx_cfg_reg;
  logic [15:0] mr_lp_adv_ability;
  logic        mr_an_complete;
  logic        link_ok;
`ifdef PCS_LINK_DROP_CNT_EN
  logic [7:0]  link_drop_cnt;
`endif

  modport master (
`ifdef PCS_LINK_DROP_CNT_EN
    input  link_drop_cnt,
`endif
    output mr_an_enable, mr_restart_an, code_sync_status,
    output rx_cfg_valid, rx_cfg_reg, rx_idle_valid,
    input  xmit, tx_cfg_reg, mr_lp_adv_ability, mr_an_complete, link_ok
  );

  modport slave (
`ifdef PCS_LINK_DROP_CNT_EN
    output link_drop_cnt,
`endif
    input  mr_an_enable, mr_restart_an, code_sync_status,
    input  rx_cfg_valid, rx_cfg_reg, rx_idle_valid,
    output xmit, tx_cfg_reg, mr_lp_adv_ability, mr_an_complete, link_ok
  );
endinterface

// File: rtl/pcs_link_ctrl.sv
// 1000BASE-X auto-negotiation link controller; outputs decode the state register, no input-to-output path except mr_an_complete.
// Optional PCS_LINK_DROP_CNT_EN adds a saturating count of LINK_OK exits.
module pcs_link_ctrl #(
  parameter int unsigned LINK_TIMER    = 16,
  parameter logic [15:0] LOCAL_ABILITY = 16'h0020
) (
  input logic            GTX_CLK,
  input logic            mr_main_reset,
  pcs_link_ctrl_if.slave bus
);

  localparam logic [19:0] TIMER_LAST = 20'(LINK_TIMER - 1);
  localparam logic [15:0] ACK_BIT    = 16'h4000;
  localparam logic [15:0] NO_ACK     = 16'hBFFF;

  typedef enum logic [2:0] {
    AN_ENABLE,
    AN_RESTART,
    ABILITY_DETECT,
    ACK_DETECT,
    COMPLETE_ACK,
    IDLE_DETECT,
    LINK_OK
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        run;
  logic [19:0] timer;
  logic [1:0]  match_cnt;
  logic [15:0] last_word;
  logic [1:0]  ack_hist;
  logic [1:0]  idle_cnt;
  logic [15:0] lp_ability;

  logic        timer_done;
  logic        same_word;
  logic [1:0]  match_nxt;
  logic        ability_match;
  logic        ack_match;
  logic        rx_zero;
  logic        rx_differs;
  logic        state_change;
  logic        entering_timer;

  assign timer_done    = (timer == TIMER_LAST);
  assign same_word     = (match_cnt != 2'd0) &&
                         ((bus.rx_cfg_reg & NO_ACK) == (last_word & NO_ACK));
  assign match_nxt     = !same_word ? 2'd1 :
                         (match_cnt == 2'd3) ? 2'd3 : match_cnt + 2'd1;
  assign ability_match = bus.rx_cfg_valid && (match_nxt == 2'd3);
  // ability_match guarantees the two previous strobes belong to the same run,
  // so the two-deep bit-14 history covers exactly the matching window.
  assign ack_match     = ability_match && bus.rx_cfg_reg[14] && (&ack_hist);
  assign rx_zero       = (bus.rx_cfg_reg == 16'h0000);
  assign rx_differs    = ((bus.rx_cfg_reg & NO_ACK) != (lp_ability & NO_ACK));
  assign state_change  = (next_state != state);
  assign entering_timer = state_change &&
                          ((next_state == AN_RESTART) ||
                           (next_state == COMPLETE_ACK) ||
                           (next_state == IDLE_DETECT));

  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state <= AN_ENABLE;
      run   <= 1'b0;
    end else begin
      state <= next_state;
      run   <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    if (!run) begin
      next_state = state;
    end else if (!bus.code_sync_status || bus.mr_restart_an) begin
      next_state = AN_ENABLE;
    end else begin
      case (state)
        AN_ENABLE: begin
          next_state = bus.mr_an_enable ? AN_RESTART : LINK_OK;
        end
        AN_RESTART: begin
          if (timer_done) next_state = ABILITY_DETECT;
        end
        ABILITY_DETECT: begin
          if (ability_match && ((bus.rx_cfg_reg & NO_ACK) != 16'h0000))
            next_state = ACK_DETECT;
        end
        ACK_DETECT: begin
          if (bus.rx_cfg_valid && (rx_zero || rx_differs))
            next_state = AN_ENABLE;
          else if (ack_match)
            next_state = COMPLETE_ACK;
        end
        COMPLETE_ACK: begin
          if (bus.rx_cfg_valid && rx_zero)
            next_state = AN_ENABLE;
          else if (timer_done)
            next_state = IDLE_DETECT;
        end
        IDLE_DETECT: begin
          if (bus.mr_an_enable && bus.rx_cfg_valid && !rx_zero)
            next_state = AN_ENABLE;
          else if (timer_done && (idle_cnt == 2'd3))
            next_state = LINK_OK;
        end
        LINK_OK: begin
          if (bus.mr_an_enable && bus.rx_cfg_valid && !rx_zero)
            next_state = AN_ENABLE;
        end
        default: next_state = AN_ENABLE;
      endcase
    end
  end

  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      timer      <= 20'd0;
      match_cnt  <= 2'd0;
      last_word  <= 16'h0000;
      ack_hist   <= 2'b00;
      idle_cnt   <= 2'd0;
      lp_ability <= 16'h0000;
    end else if (run) begin
      if (entering_timer)
        timer <= 20'd0;
      else if (!timer_done)
        timer <= timer + 20'd1;

      if (state_change) begin
        match_cnt <= 2'd0;
        last_word <= 16'h0000;
        ack_hist  <= 2'b00;
        idle_cnt  <= 2'd0;
      end else begin
        if (bus.rx_cfg_valid) begin
          match_cnt <= match_nxt;
          last_word <= bus.rx_cfg_reg;
          ack_hist  <= {ack_hist[0], bus.rx_cfg_reg[14]};
        end
        if (bus.rx_cfg_valid)
          idle_cnt <= 2'd0;
        else if (bus.rx_idle_valid && (idle_cnt != 2'd3))
          idle_cnt <= idle_cnt + 2'd1;
      end

      if ((state == ABILITY_DETECT) && (next_state == ACK_DETECT))
        lp_ability <= bus.rx_cfg_reg;
    end
  end

  logic [2:0]  xmit_d;
  logic [15:0] tx_cfg_d;
  logic        link_d;

  always_comb begin
    xmit_d   = 3'b001;
    tx_cfg_d = 16'h0000;
    link_d   = 1'b0;
    case (state)
      ABILITY_DETECT: tx_cfg_d = LOCAL_ABILITY;
      ACK_DETECT,
      COMPLETE_ACK:   tx_cfg_d = LOCAL_ABILITY | ACK_BIT;
      IDLE_DETECT:    xmit_d   = 3'b010;
      LINK_OK: begin
        xmit_d = 3'b100;
        link_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.xmit              = xmit_d;
  assign bus.tx_cfg_reg        = tx_cfg_d;
  assign bus.link_ok           = link_d;
  assign bus.mr_an_complete    = link_d & bus.mr_an_enable;
  assign bus.mr_lp_adv_ability = lp_ability;

`ifdef PCS_LINK_DROP_CNT_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset)
      drop_cnt <= 8'h00;
    else if (run && (state == LINK_OK) && state_change && (drop_cnt != 8'hFF))
      drop_cnt <= drop_cnt + 8'h01;
  end

  assign bus.link_drop_cnt = drop_cnt;
`endif

endmodule

// File: tb/tb_pcs_link_ctrl.sv
// Directed bench for pcs_link_ctrl: a history-based reference model checked every cycle,
// plus literal expectations for the key protocol milestones.
module tb_pcs_link_ctrl;
  localparam int          LT     = 16;
  localparam logic [15:0] LA     = 16'h0020;
  localparam logic [15:0] NO_ACK = 16'hBFFF;

  localparam int M_EN = 0, M_RST = 1, M_ABIL = 2, M_ACK = 3, M_CACK = 4, M_IDLE = 5, M_LINK = 6;

  logic GTX_CLK = 1'b0;
  logic mr_main_reset = 1'b1;
  pcs_link_ctrl_if bus();

  int checks = 0;
  int errors = 0;

  pcs_link_ctrl #(.LINK_TIMER(LT), .LOCAL_ABILITY(LA)) dut (
    .GTX_CLK(GTX_CLK),
    .mr_main_reset(mr_main_reset),
    .bus(bus)
  );

  always #5 GTX_CLK = ~GTX_CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: state label, cycles since entering it, and the cfg words seen since entry.
  int          m_st = M_EN;
  bit          m_run = 1'b0;
  int          m_age = 0;
  int          m_idle = 0;
  int          m_drops = 0;
  logic [15:0] m_lp = 16'h0000;
  logic [15:0] m_hist[$];
  logic [15:0] mw;
  bit          mv, m_abm, m_ackm, m_done;
  int          m_nxt, qn;

  always @(posedge GTX_CLK) begin
    if (mr_main_reset) begin
      m_st = M_EN; m_run = 1'b0; m_age = 0; m_idle = 0; m_drops = 0; m_lp = 16'h0000;
      m_hist.delete();
    end else if (!m_run) begin
      m_run = 1'b1;
    end else begin
      mw = bus.rx_cfg_reg;
      mv = bus.rx_cfg_valid;
      m_done = (m_age >= LT - 1);
      qn = m_hist.size();
      m_abm = 1'b0;
      m_ackm = 1'b0;
      if (mv && qn >= 2) begin
        m_abm = ((m_hist[qn-1] & NO_ACK) == (mw & NO_ACK)) &&
                ((m_hist[qn-2] & NO_ACK) == (mw & NO_ACK));
        m_ackm = m_abm && mw[14] && m_hist[qn-1][14] && m_hist[qn-2][14];
      end
      m_nxt = m_st;
      if (!bus.code_sync_status || bus.mr_restart_an) m_nxt = M_EN;
      else case (m_st)
        M_EN:   m_nxt = bus.mr_an_enable ? M_RST : M_LINK;
        M_RST:  if (m_done) m_nxt = M_ABIL;
        M_ABIL: if (m_abm && (mw & NO_ACK) != 0) m_nxt = M_ACK;
        M_ACK:  if (mv && (mw == 0 || (mw & NO_ACK) != (m_lp & NO_ACK))) m_nxt = M_EN;
                else if (m_ackm) m_nxt = M_CACK;
        M_CACK: if (mv && mw == 0) m_nxt = M_EN; else if (m_done) m_nxt = M_IDLE;
        M_IDLE: if (bus.mr_an_enable && mv && mw != 0) m_nxt = M_EN;
                else if (m_done && m_idle >= 3) m_nxt = M_LINK;
        M_LINK: if (bus.mr_an_enable && mv && mw != 0) m_nxt = M_EN;
        default: m_nxt = M_EN;
      endcase
      if (m_st == M_ABIL && m_nxt == M_ACK) m_lp = mw;
      if (m_st == M_LINK && m_nxt != M_LINK && m_drops < 255) m_drops++;
      if (m_nxt != m_st) begin
        m_hist.delete();
        m_idle = 0;
        m_age = (m_nxt == M_RST || m_nxt == M_CACK || m_nxt == M_IDLE) ? 0 : m_age + 1;
      end else begin
        if (mv) begin
          m_hist.push_back(mw);
          while (m_hist.size() > 2) void'(m_hist.pop_front());
          m_idle = 0;
        end else if (bus.rx_idle_valid) begin
          m_idle++;
        end
        m_age++;
      end
      m_st = m_nxt;
    end
  end

  always @(posedge GTX_CLK) begin
    #1;
    chk("xmit", {29'd0, bus.xmit},
        (m_st == M_LINK) ? 32'd4 : (m_st == M_IDLE) ? 32'd2 : 32'd1);
    chk("tx_cfg_reg", {16'd0, bus.tx_cfg_reg},
        (m_st == M_ABIL) ? {16'd0, LA} :
        (m_st == M_ACK || m_st == M_CACK) ? {16'd0, LA | 16'h4000} : 32'd0);
    chk("lp_adv", {16'd0, bus.mr_lp_adv_ability}, {16'd0, m_lp});
    chk("link_ok", {31'd0, bus.link_ok}, {31'd0, m_st == M_LINK});
    chk("an_complete", {31'd0, bus.mr_an_complete}, {31'd0, (m_st == M_LINK) && bus.mr_an_enable});
`ifdef PCS_LINK_DROP_CNT_EN
    chk("drop_cnt", {24'd0, bus.link_drop_cnt}, m_drops);
`endif
  end

  task automatic tick();
    @(negedge GTX_CLK);
  endtask

  task automatic send_cfg(input logic [15:0] w);
    bus.rx_cfg_valid = 1'b1;
    bus.rx_cfg_reg = w;
    tick();
    bus.rx_cfg_valid = 1'b0;
  endtask

  task automatic wait_tx(input logic [15:0] v);
    int n = 0;
    while (bus.tx_cfg_reg !== v && n < 200) begin tick(); n++; end
    chk("wait_tx", {16'd0, bus.tx_cfg_reg}, {16'd0, v});
  endtask

  task automatic wait_xmit(input logic [2:0] v, input bit idles);
    int n = 0;
    while (bus.xmit !== v && n < 200) begin
      bus.rx_idle_valid = idles;
      tick();
      n++;
    end
    bus.rx_idle_valid = 1'b0;
    chk("wait_xmit", {29'd0, bus.xmit}, {29'd0, v});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bus.mr_an_enable = 1'b1;
    bus.mr_restart_an = 1'b0;
    bus.code_sync_status = 1'b1;
    bus.rx_cfg_valid = 1'b0;
    bus.rx_cfg_reg = 16'h0000;
    bus.rx_idle_valid = 1'b0;
    repeat (3) tick();
    chk("rst_xmit", {29'd0, bus.xmit}, 32'd1);
    chk("rst_tx", {16'd0, bus.tx_cfg_reg}, 32'd0);
    chk("rst_link", {31'd0, bus.link_ok}, 32'd0);
`ifdef PCS_LINK_DROP_CNT_EN
    chk("rst_drop", {24'd0, bus.link_drop_cnt}, 32'd0);
`endif

    // Full negotiation: release, two-edge start, 16-cycle restart timer.
    mr_main_reset = 1'b0;
    n = 0;
    do begin @(posedge GTX_CLK); #1; n++; end
    while (bus.tx_cfg_reg !== 16'h0020 && n < 100);
    chk("restart_edges", n, 32'd18);
    tick();
    repeat (3) send_cfg(16'h0020);
    chk("ack_tx", {16'd0, bus.tx_cfg_reg}, 32'h4020);
    chk("lp_latched", {16'd0, bus.mr_lp_adv_ability}, 32'h0020);
    repeat (3) send_cfg(16'h4020);
    wait_xmit(3'b010, 1'b0);
    wait_xmit(3'b100, 1'b1);
    chk("link_up", {31'd0, bus.link_ok}, 32'd1);
    chk("complete", {31'd0, bus.mr_an_complete}, 32'd1);
    chk("lp_final", {16'd0, bus.mr_lp_adv_ability}, 32'h0020);

    // Sync loss drops the link on the next edge.
    bus.code_sync_status = 1'b0;
    @(posedge GTX_CLK); #1;
    chk("drop_link", {31'd0, bus.link_ok}, 32'd0);
    chk("drop_xmit", {29'd0, bus.xmit}, 32'd1);
`ifdef PCS_LINK_DROP_CNT_EN
    chk("drop_cnt_one", {24'd0, bus.link_drop_cnt}, 32'd1);
`endif
    tick();
    bus.code_sync_status = 1'b1;

    // Mismatching word during ACK_DETECT aborts back to AN_ENABLE.
    wait_tx(16'h0020);
    repeat (3) send_cfg(16'h0020);
    send_cfg(16'h0040);
    chk("abort_xmit", {29'd0, bus.xmit}, 32'd1);
    chk("abort_tx", {16'd0, bus.tx_cfg_reg}, 32'd0);

    // Matching window: stray words before the run, partial-ack words before the acked run.
    wait_tx(16'h0020);
    send_cfg(16'h0020);
    send_cfg(16'h41A0);
    send_cfg(16'h01A0);
    send_cfg(16'h01A0);
    chk("lp_window", {16'd0, bus.mr_lp_adv_ability}, 32'h01A0);
    send_cfg(16'h41A0);
    send_cfg(16'h01A0);
    repeat (2) send_cfg(16'h41A0);
    chk("ack_wait", {16'd0, bus.tx_cfg_reg}, 32'h4020);
    send_cfg(16'h41A0);
    wait_xmit(3'b010, 1'b0);
    repeat (3) begin bus.rx_idle_valid = 1'b1; tick(); end
    bus.rx_idle_valid = 1'b0;
    send_cfg(16'h0000);
    wait_xmit(3'b100, 1'b1);
    send_cfg(16'h0001);
    chk("relink_xmit", {29'd0, bus.xmit}, 32'd1);

    // Restart held high pins the controller in AN_ENABLE.
    tick();
    bus.mr_restart_an = 1'b1;
    repeat (3) tick();
    chk("restart_hold", {29'd0, bus.xmit}, 32'd1);
    bus.mr_restart_an = 1'b0;

    // Asynchronous reset in the middle of COMPLETE_ACK.
    wait_tx(16'h0020);
    repeat (3) send_cfg(16'h0020);
    repeat (3) send_cfg(16'h4020);
    repeat (3) tick();
    @(posedge GTX_CLK); #3;
    mr_main_reset = 1'b1;
    #1;
    chk("async_xmit", {29'd0, bus.xmit}, 32'd1);
    chk("async_tx", {16'd0, bus.tx_cfg_reg}, 32'd0);
    chk("async_lp", {16'd0, bus.mr_lp_adv_ability}, 32'd0);
    chk("async_link", {31'd0, bus.link_ok}, 32'd0);
    bus.mr_an_enable = 1'b0;
    repeat (2) tick();

    // Bypass mode: link by sync alone, on the second edge after release.
    mr_main_reset = 1'b0;
    @(posedge GTX_CLK); #1;
    chk("bypass_edge1", {29'd0, bus.xmit}, 32'd1);
    @(posedge GTX_CLK); #1;
    chk("bypass_xmit", {29'd0, bus.xmit}, 32'd4);
    chk("bypass_complete", {31'd0, bus.mr_an_complete}, 32'd0);
    chk("bypass_link", {31'd0, bus.link_ok}, 32'd1);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
